// File: rtl/credit_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : credit_stream_buffer
// Purpose  : Sits at the output of a valid-only, non-stallable pipeline and
//            turns it into a ready/valid stream with backpressure. Entries are
//            held in a circular FIFO of Depth slots. A credit counter, seeded
//            with Depth, stops the issuer at the pipeline head from launching
//            more transactions than the FIFO can absorb.
//
// Optional : CREDIT_STREAM_BUFFER_BYPASS_EN
//            Defined   - when the FIFO is empty, a pipeline output goes
//                        straight to valid_o/data_o in the same cycle. If it
//                        is accepted there, it is never written to storage.
//            Undefined - outputs come only from registered state, so the
//                        minimum latency is one cycle.
//
// Ports    : clk_i          clock, all state updates on the rising edge
//            rst_i          asynchronous reset, active-high
//            issue_i        issuer launches a transaction (consumes a credit)
//            credit_avail_o at least one credit available
//            credit_o       current credit count            [CntW]
//            valid_i        pipeline output valid (cannot be stalled)
//            data_i         pipeline output data            [Width]
//            valid_o        head entry valid
//            ready_i        downstream accepts head entry
//            data_o         head entry data, 0 when empty   [Width]
//            count_o        FIFO occupancy                  [CntW]
//            overflow_o     sticky: push dropped or issue without credit
//
// Revision : 1.0 - initial release
// ============================================================================
module credit_stream_buffer #(
  parameter  int Depth = 4,
  parameter  int Width = 32,
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             issue_i,
  output logic             credit_avail_o,
  output logic [CntW-1:0]  credit_o,
  input  logic             valid_i,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic [CntW-1:0]  count_o,
  output logic             overflow_o
);

  localparam int              PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [CntW-1:0] c_depth = CntW'(Depth);
  localparam logic [PtrW-1:0] c_last  = PtrW'(Depth - 1);

  // Storage carries no reset; only the pointers and count say what is live.
  logic [Width-1:0] mem_q [Depth];

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q,  count_d;
  logic [CntW-1:0] credit_q, credit_d;
  logic            overflow_q, overflow_d;

  logic fifo_nonempty;  // storage holds at least one entry
  logic bypass_take;    // incoming entry consumed directly, never stored
  logic pop;            // downstream handshake (storage or bypass)
  logic fifo_pop;       // handshake that drains an entry from storage
  logic push_wr;        // incoming entry is written to storage
  logic push_drop;      // incoming entry lost because storage is full
  logic issue;          // issue that actually consumes a credit

  // --------------------------------------------------------------------------
  // Output view of the head entry
  // --------------------------------------------------------------------------
  always_comb begin
    fifo_nonempty = (count_q != '0);
`ifdef CREDIT_STREAM_BUFFER_BYPASS_EN
    // Empty buffer: the pipeline output becomes the head in the same cycle.
    valid_o     = fifo_nonempty | valid_i;
    data_o      = fifo_nonempty ? mem_q[rd_ptr_q] : (valid_i ? data_i : '0);
    bypass_take = ~fifo_nonempty & valid_i & ready_i;
`else
    valid_o     = fifo_nonempty;
    data_o      = fifo_nonempty ? mem_q[rd_ptr_q] : '0;
    bypass_take = 1'b0;
`endif
  end

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  always_comb begin
    pop      = valid_o & ready_i;
    fifo_pop = fifo_nonempty & ready_i;
    // A full buffer can still take a push if the head leaves this cycle.
    push_wr   = valid_i & ~bypass_take & ((count_q != c_depth) | fifo_pop);
    push_drop = valid_i & ~bypass_take & ~push_wr;
    issue     = issue_i & (credit_q != '0);
  end

  // --------------------------------------------------------------------------
  // Next-state
  // --------------------------------------------------------------------------
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    // Explicit wrap because Depth need not be a power of two.
    if (fifo_pop) begin
      rd_ptr_d = (rd_ptr_q == c_last) ? '0 : rd_ptr_q + PtrW'(1);
    end
    if (push_wr) begin
      wr_ptr_d = (wr_ptr_q == c_last) ? '0 : wr_ptr_q + PtrW'(1);
    end

    count_d  = count_q + CntW'(push_wr) - CntW'(fifo_pop);
    // A bypassed entry still hands its credit back through pop.
    credit_d = credit_q + CntW'(pop) - CntW'(issue);

    overflow_d = overflow_q | push_drop | (issue_i & (credit_q == '0));
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= c_depth;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_wr) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign credit_o       = credit_q;
  assign credit_avail_o = (credit_q != '0);
  assign count_o        = count_q;
  assign overflow_o     = overflow_q;

`ifndef SYNTHESIS
  // Every entry was issued against a credit, so while anything is poppable
  // the counter must sit below Depth.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (!rst_i) begin
      assert (!(pop && (credit_q == c_depth)));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_credit_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_credit_stream_buffer
// Purpose  : Self-checking bench for credit_stream_buffer. Two instances are
//            used: Depth=4 for the main checks and Depth=3 for pointer wrap.
//            Every cycle is compared against a queue-based reference model.
//            The model also has to track CREDIT_STREAM_BUFFER_BYPASS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_credit_stream_buffer;

  localparam int c_lat = 3;  // pipeline latency used by the random phase

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        issue_r [2];
  logic        valid_r [2];
  logic        ready_r [2];
  logic [31:0] data_r  [2];

  logic        ca0, ca1, v0, v1, of0, of1;
  logic [2:0]  cr0, cn0;
  logic [1:0]  cr1, cn1;
  logic [31:0] d0, d1;

  credit_stream_buffer #(.Depth(4), .Width(32)) u_dut4 (
    .clk_i(clk), .rst_i(rst), .issue_i(issue_r[0]), .credit_avail_o(ca0),
    .credit_o(cr0), .valid_i(valid_r[0]), .data_i(data_r[0]), .valid_o(v0),
    .ready_i(ready_r[0]), .data_o(d0), .count_o(cn0), .overflow_o(of0)
  );

  credit_stream_buffer #(.Depth(3), .Width(32)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .issue_i(issue_r[1]), .credit_avail_o(ca1),
    .credit_o(cr1), .valid_i(valid_r[1]), .data_i(data_r[1]), .valid_o(v1),
    .ready_i(ready_r[1]), .data_o(d1), .count_o(cn1), .overflow_o(of1)
  );

  // ---------------- reference model ----------------
  int          dep [2] = '{4, 3};
  int          mcredit [2];
  logic        movf [2];
  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];

  int n_chk = 0;
  int n_err = 0;

  function automatic int qsize(int k);
    return (k == 0) ? mq0.size() : mq1.size();
  endfunction

  function automatic logic [31:0] qhead(int k);
    return (k == 0) ? mq0[0] : mq1[0];
  endfunction

  function automatic logic model_bypass(int k);
`ifdef CREDIT_STREAM_BUFFER_BYPASS_EN
    return (qsize(k) == 0) && valid_r[k];
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic expect_outputs(int k);
    int          sz;
    logic        byp;
    logic        ev;
    logic [31:0] ed;
    sz  = qsize(k);
    byp = model_bypass(k);
    ev  = (sz != 0) || byp;
    ed  = (sz != 0) ? qhead(k) : (byp ? data_r[k] : 32'h0);
    if (k == 0) begin
      chk("valid0", {31'b0, v0}, {31'b0, ev});
      chk("data0", d0, ed);
      chk("count0", {29'b0, cn0}, sz);
      chk("credit0", {29'b0, cr0}, mcredit[0]);
      chk("avail0", {31'b0, ca0}, {31'b0, mcredit[0] != 0});
      chk("ovf0", {31'b0, of0}, {31'b0, movf[0]});
    end else begin
      chk("valid1", {31'b0, v1}, {31'b0, ev});
      chk("data1", d1, ed);
      chk("count1", {30'b0, cn1}, sz);
      chk("credit1", {30'b0, cr1}, mcredit[1]);
      chk("avail1", {31'b0, ca1}, {31'b0, mcredit[1] != 0});
      chk("ovf1", {31'b0, of1}, {31'b0, movf[1]});
    end
  endtask

  task automatic model_update(int k);
    int   sz;
    logic byp, ev, pop, fpop;
    sz   = qsize(k);
    byp  = model_bypass(k);
    ev   = (sz != 0) || byp;
    pop  = ev && ready_r[k];
    fpop = (sz != 0) && ready_r[k];
    if (issue_r[k] && mcredit[k] == 0) movf[k] = 1'b1;
    mcredit[k] = mcredit[k] - ((issue_r[k] && mcredit[k] > 0) ? 1 : 0) + (pop ? 1 : 0);
    if (fpop) begin
      if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
    end
    if (valid_r[k] && !(byp && ready_r[k])) begin
      if (sz < dep[k] || fpop) begin
        if (k == 0) mq0.push_back(data_r[k]); else mq1.push_back(data_r[k]);
      end else begin
        movf[k] = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcredit[k] = dep[k];
      movf[k]    = 1'b0;
    end
    mq0.delete();
    mq1.delete();
  endtask

  // Called just after a rising edge with inputs already set for this cycle.
  task automatic tick();
    #1;
    for (int k = 0; k < 2; k++) expect_outputs(k);
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_update(k);
    #1;
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      issue_r[k] = 1'b0;
      valid_r[k] = 1'b0;
      ready_r[k] = 1'b0;
      data_r[k]  = 32'h0;
    end
  endtask

  // Assert reset between edges and check that outputs respond without a clock.
  task automatic reset_assert();
    idle_inputs();
    rst = 1'b1;
    #2;
    model_reset();
    for (int k = 0; k < 2; k++) expect_outputs(k);
  endtask

  task automatic reset_release();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- random-phase pipeline model ----------------
  logic        pipe_v [2][c_lat];
  logic [31:0] pipe_d [2][c_lat];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish within time bound");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    model_reset();
    @(posedge clk);
    #1;
    reset_assert();
    reset_release();

    // Reset values and idle
    chk("rst_credit", {29'b0, cr0}, 32'd4);
    chk("rst_count", {29'b0, cn0}, 32'd0);
    chk("rst_valid", {31'b0, v0}, 32'd0);
    chk("rst_ovf", {31'b0, of0}, 32'd0);
    chk("rst_avail", {31'b0, ca0}, 32'd1);
    tick();
    tick();

    // Fill with 4 entries, then drain in order
    for (int i = 0; i < 4; i++) begin issue_r[0] = 1'b1; tick(); end
    issue_r[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_r[0] = 1'b1; data_r[0] = 32'hA0 + i; tick();
    end
    valid_r[0] = 1'b0;
    chk("full_credit", {29'b0, cr0}, 32'd0);
    chk("full_count", {29'b0, cn0}, 32'd4);
    chk("full_avail", {31'b0, ca0}, 32'd0);
    ready_r[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("drain_data", d0, 32'hA0 + i);
      tick();
    end
    ready_r[0] = 1'b0;
    chk("drain_credit", {29'b0, cr0}, 32'd4);
    chk("drain_count", {29'b0, cn0}, 32'd0);

    // Async reset mid-burst with three entries held
    for (int i = 0; i < 3; i++) begin issue_r[0] = 1'b1; tick(); end
    issue_r[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_r[0] = 1'b1; data_r[0] = 32'hD0 + i; tick();
    end
    valid_r[0] = 1'b0;
    chk("pre_rst_count", {29'b0, cn0}, 32'd3);
    reset_assert();
    chk("arst_count", {29'b0, cn0}, 32'd0);
    chk("arst_credit", {29'b0, cr0}, 32'd4);
    chk("arst_valid", {31'b0, v0}, 32'd0);
    chk("arst_data", d0, 32'd0);
    reset_release();

    // Full FIFO: push with pop accepted, push without pop dropped
    for (int i = 0; i < 4; i++) begin issue_r[0] = 1'b1; tick(); end
    issue_r[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_r[0] = 1'b1; data_r[0] = 32'hB0 + i; tick();
    end
    valid_r[0] = 1'b1; data_r[0] = 32'hBE; ready_r[0] = 1'b1;
    tick();
    chk("fullpp_count", {29'b0, cn0}, 32'd4);
    chk("fullpp_ovf", {31'b0, of0}, 32'd0);
    chk("fullpp_head", d0, 32'hB1);
    valid_r[0] = 1'b1; data_r[0] = 32'hBF; ready_r[0] = 1'b0;
    tick();
    valid_r[0] = 1'b0;
    chk("drop_count", {29'b0, cn0}, 32'd4);
    chk("drop_ovf", {31'b0, of0}, 32'd1);
    tick();
    chk("drop_ovf_sticky", {31'b0, of0}, 32'd1);
    reset_assert();
    reset_release();

    // Issue without credit; simultaneous issue and pop
    for (int i = 0; i < 4; i++) begin issue_r[0] = 1'b1; tick(); end
    tick();
    issue_r[0] = 1'b0;
    chk("nocred_credit", {29'b0, cr0}, 32'd0);
    chk("nocred_ovf", {31'b0, of0}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      valid_r[0] = 1'b1; data_r[0] = 32'hE0 + i; tick();
    end
    valid_r[0] = 1'b0;
    ready_r[0] = 1'b1;
    tick();
    tick();
    chk("pre_ip_credit", {29'b0, cr0}, 32'd2);
    issue_r[0] = 1'b1;
    tick();
    issue_r[0] = 1'b0;
    ready_r[0] = 1'b0;
    chk("issue_pop_credit", {29'b0, cr0}, 32'd2);
    reset_assert();
    reset_release();

    // Depth=3 streaming: ten items with ready held high
    for (int i = 0; i < 10; i++) begin
      issue_r[1] = 1'b1; valid_r[1] = 1'b1; data_r[1] = 32'hC0 + i; ready_r[1] = 1'b1;
      #1;
`ifdef CREDIT_STREAM_BUFFER_BYPASS_EN
      chk("wrap_valid", {31'b0, v1}, 32'd1);
      chk("wrap_data", d1, 32'hC0 + i);
`else
      if (i == 0) begin
        chk("wrap_valid", {31'b0, v1}, 32'd0);
      end else begin
        chk("wrap_valid", {31'b0, v1}, 32'd1);
        chk("wrap_data", d1, 32'hC0 + i - 1);
      end
`endif
      tick();
      chk("wrap_cnt_le1", {31'b0, cn1 <= 2'd1}, 32'd1);
    end
    issue_r[1] = 1'b0; valid_r[1] = 1'b0;
    tick();
    ready_r[1] = 1'b0;
    chk("wrap_credit", {30'b0, cr1}, 32'd3);
    chk("wrap_count", {30'b0, cn1}, 32'd0);

    // Latency through an empty buffer
    issue_r[0] = 1'b1; valid_r[0] = 1'b1; data_r[0] = 32'h55; ready_r[0] = 1'b1;
    #1;
`ifdef CREDIT_STREAM_BUFFER_BYPASS_EN
    chk("lat_same_valid", {31'b0, v0}, 32'd1);
    chk("lat_same_data", d0, 32'h55);
`else
    chk("lat_same_valid", {31'b0, v0}, 32'd0);
    chk("lat_same_data", d0, 32'h0);
`endif
    tick();
    issue_r[0] = 1'b0; valid_r[0] = 1'b0; data_r[0] = 32'h0;
    #1;
`ifdef CREDIT_STREAM_BUFFER_BYPASS_EN
    chk("lat_next_valid", {31'b0, v0}, 32'd0);
`else
    chk("lat_next_valid", {31'b0, v0}, 32'd1);
    chk("lat_next_data", d0, 32'h55);
`endif
    tick();
    ready_r[0] = 1'b0;
    chk("lat_count", {29'b0, cn0}, 32'd0);
    chk("lat_credit", {29'b0, cr0}, 32'd4);

    // Randomized traffic on both instances through a fixed-latency pipeline
    reset_assert();
    reset_release();
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < c_lat; j++) begin pipe_v[k][j] = 1'b0; pipe_d[k][j] = 32'h0; end
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        valid_r[k] = pipe_v[k][c_lat-1];
        data_r[k]  = pipe_d[k][c_lat-1];
        issue_r[k] = ($urandom_range(0, 3) != 0) && (mcredit[k] > 0);
        ready_r[k] = (n % 200 < 100) ? ($urandom_range(0, 3) == 0)
                                     : ($urandom_range(0, 3) != 0);
      end
      tick();
      for (int k = 0; k < 2; k++) begin
        for (int j = c_lat - 1; j > 0; j--) begin
          pipe_v[k][j] = pipe_v[k][j-1];
          pipe_d[k][j] = pipe_d[k][j-1];
        end
        pipe_v[k][0] = issue_r[k];
        pipe_d[k][0] = $urandom;
      end
    end
    idle_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
